hir_call_scheduler: RTL and testbench
=====================================

# hir_call_scheduler

Shares one instance of an HIR-generated kernel (tstart-triggered, fixed latency, fixed initiation interval) among several callers. Accepts call requests with one argument word each, grants them round-robin, issues a single-cycle `tstart` plus the latched argument to the kernel no more often than the kernel's initiation interval, and returns a per-caller `done` pulse exactly LATENCY cycles after each launch. Sits between the caller FSMs and the kernel's `tstart`/argument inputs; the kernel's memory ports are untouched.

## Interface
- N_CALLERS, 4: number of requesters, ≥2
- ARG_W, 32: argument word width
- II, 2: kernel initiation interval in cycles, ≥1
- LATENCY, 5: cycles from `tstart` to kernel result valid, ≥1

- clk  in  1  clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- req  in  N_CALLERS  level request per caller, held until its `gnt` bit is seen
- arg  in  N_CALLERS×ARG_W  per-caller argument, stable while `req` high
- gnt  out  N_CALLERS  one-hot, one-cycle grant pulse
- tstart  out  1  one-cycle kernel launch pulse, coincident with `gnt`
- karg  out  ARG_W  argument of granted caller, valid in `tstart` cycle, held afterwards
- done  out  N_CALLERS  one-hot, one-cycle completion pulse to the launching caller
- busy  out  1  high while any call is granted or in flight

## Operation
- Eligible set = `req & ~gnt` (the caller granted last cycle is masked, so a held `req` is never double-granted).
- Launch permitted when II counter = 0 and the eligible set is non-empty.
- Round-robin pick: search starts at (last_grant + 1) mod N_CALLERS; last_grant updated on every launch only.
- On launch: register `gnt[id]=1`, `tstart=1`, `karg=arg[id]`; load II counter with II−1 (II=1 → counter stays 0, back-to-back launches allowed).
- II counter decrements to 0 and saturates.
- In-flight tracking: shift pipeline of LATENCY stages, each {valid, id}; stage 0 loaded in the `tstart` cycle; `done[id]` asserted when the entry leaves the last stage.
- At most one entry per stage (II≥1), so `done` is always one-hot or zero.
- `busy` = `tstart` OR any pipeline stage valid.
- Caller contract: may drop `req` the cycle after its `gnt`; may re-raise it any time, including before its own `done`.

## Timing
- Reset values: `gnt`=0, `tstart`=0, `karg`=0, `done`=0, `busy`=0, II counter=0, pipeline valids=0, last_grant=N_CALLERS−1 (caller 0 wins first).
- Request-to-launch latency: `req` sampled at edge t → `gnt`/`tstart` high in cycle t+1 (registered).
- Launch-to-done: `tstart` in cycle T → `done` in cycle T+LATENCY.
- Consecutive launches spaced ≥ II cycles; with all callers requesting, launches occur exactly every II cycles.
- Simultaneous `done` for caller k and a new `gnt` to caller k in the same cycle: both asserted.
- `rst` mid-operation: pending and in-flight calls are dropped, no `done` issued for them; outputs return to reset values the cycle after `rst` is sampled.
- `req` dropped before grant: request withdrawn, never granted.

## Structure
- Package `hir_sched_pkg`: `caller_id_t` (width $clog2(N_CALLERS)), in-flight entry struct {valid, id}, default parameter constants.
- Sub-module `rr_arbiter`: combinational round-robin picker (eligible vector + last_grant → one-hot grant + id, any-valid). The top holds the II counter, output registers and the done pipeline.

## Test plan
- Single call: caller 2 raises `req` with `arg`=0x5 at cycle 10 → `gnt[2]`, `tstart`, `karg`=0x5 at cycle 11; `done[2]` at cycle 16; `busy` high cycles 11–15 inclusive.
- All four requesting from reset, II=2 → grants to 0,1,2,3 at cycles +1,+3,+5,+7; `done` 0..3 at +6,+8,+10,+12.
- II=1, callers 0 and 1 continuously requesting → alternating grants every cycle, no caller granted twice in consecutive cycles.
- Held `req`: caller 1 keeps `req` high one cycle after `gnt` with other callers idle → exactly one grant; second grant only after deassert/re-raise, spaced ≥ II.
- Reset at cycle T with two calls in flight → no `done` pulses afterwards, all outputs 0 from T+1, next grant goes to caller 0.
- Withdrawn request: caller 3 raises `req` while II counter nonzero and drops it before counter reaches 0 → no `gnt[3]`, no `tstart`.

Source files
------------

// File: rtl/hir_call_scheduler_pkg.sv
// Shared types and defaults for the HIR kernel call scheduler.
// Caller ids, in-flight pipeline entries and default parameter values.
package hir_sched_pkg;

    localparam int DEF_N_CALLERS = 4;
    localparam int DEF_ARG_W     = 32;
    localparam int DEF_II        = 2;
    localparam int DEF_LATENCY   = 5;
    localparam int ID_W          = $clog2(DEF_N_CALLERS);

    typedef logic [ID_W-1:0] caller_id_t;

    typedef struct packed {
        logic       valid;
        caller_id_t id;
    } inflight_t;

    // Wraps an index in [0, 2n) back into [0, n) without a modulo operator.
    function automatic int wrap_idx(input int idx, input int n);
        return (idx >= n) ? idx - n : idx;
    endfunction

endpackage

// File: rtl/hir_call_scheduler_rr_arbiter.sv
// Combinational round-robin picker: the search starts one past the last grant.
// Produces a one-hot grant, the matching id and an any-valid flag.
module rr_arbiter
    import hir_sched_pkg::*;
#(
    parameter int N_CALLERS = DEF_N_CALLERS
) (
    input  logic [N_CALLERS-1:0] eligible,
    input  caller_id_t           last_grant,
    output logic [N_CALLERS-1:0] grant,
    output caller_id_t           grant_id,
    output logic                 any
);

    always_comb begin
        int         idx;
        caller_id_t cid;
        grant    = '0;
        grant_id = last_grant;
        any      = 1'b0;
        idx      = 0;
        cid      = '0;
        for (int i = 1; i <= N_CALLERS; i++) begin
            idx = wrap_idx(int'(last_grant) + i, N_CALLERS);
            cid = caller_id_t'(idx);
            if (!any && eligible[cid]) begin
                any        = 1'b1;
                grant[cid] = 1'b1;
                grant_id   = cid;
            end
        end
    end

endmodule

// File: rtl/hir_call_scheduler.sv
// Shares one fixed-latency, fixed-II kernel among several callers: round-robin
// launch arbitration, II pacing and a per-caller done pulse LATENCY cycles later.
module hir_call_scheduler
    import hir_sched_pkg::*;
#(
    parameter int N_CALLERS = DEF_N_CALLERS,
    parameter int ARG_W     = DEF_ARG_W,
    parameter int II        = DEF_II,
    parameter int LATENCY   = DEF_LATENCY
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_CALLERS-1:0]       req,
    input  logic [N_CALLERS*ARG_W-1:0] arg,
    output logic [N_CALLERS-1:0]       gnt,
    output logic                       tstart,
    output logic [ARG_W-1:0]           karg,
    output logic [N_CALLERS-1:0]       done,
    output logic                       busy
);

    localparam int II_W = (II > 1) ? $clog2(II) : 1;

    logic [N_CALLERS-1:0] gnt_q, gnt_d;
    logic                 tstart_q, tstart_d;
    logic [ARG_W-1:0]     karg_q, karg_d;
    logic [N_CALLERS-1:0] done_q, done_d;
    logic [II_W-1:0]      ii_q, ii_d;
    caller_id_t           last_q, last_d;
    inflight_t            pipe_q [LATENCY];
    inflight_t            pipe_d [LATENCY];

    logic [N_CALLERS-1:0] eligible;
    logic [N_CALLERS-1:0] arb_grant;
    caller_id_t           arb_id;
    logic                 arb_any;
    logic                 launch;
    logic                 any_vld;

    // The caller granted last cycle is masked so a still-held req is not re-granted.
    assign eligible = req & ~gnt_q;

    rr_arbiter #(
        .N_CALLERS (N_CALLERS)
    ) u_arb (
        .eligible   (eligible),
        .last_grant (last_q),
        .grant      (arb_grant),
        .grant_id   (arb_id),
        .any        (arb_any)
    );

    always_comb begin
        launch   = arb_any && (ii_q == '0);
        gnt_d    = launch ? arb_grant : '0;
        tstart_d = launch;
        karg_d   = launch ? arg[arb_id*ARG_W +: ARG_W] : karg_q;
        last_d   = launch ? arb_id : last_q;
        if (launch) begin
            ii_d = II_W'(II - 1);
        end else if (ii_q != '0) begin
            ii_d = ii_q - 1'b1;
        end else begin
            ii_d = ii_q;
        end

        // Stage 0 is written on the launch edge, so the last stage retires at T+LATENCY.
        pipe_d[0] = '{valid: launch, id: arb_id};
        for (int k = 1; k < LATENCY; k++) begin
            pipe_d[k] = pipe_q[k-1];
        end

        done_d = '0;
        if (pipe_q[LATENCY-1].valid) begin
            done_d[pipe_q[LATENCY-1].id] = 1'b1;
        end

        any_vld = 1'b0;
        for (int k = 0; k < LATENCY; k++) begin
            any_vld = any_vld | pipe_q[k].valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q    <= '0;
            tstart_q <= 1'b0;
            karg_q   <= '0;
            done_q   <= '0;
            ii_q     <= '0;
            last_q   <= caller_id_t'(N_CALLERS - 1);
            for (int k = 0; k < LATENCY; k++) begin
                pipe_q[k].valid <= 1'b0;
            end
        end else begin
            gnt_q    <= gnt_d;
            tstart_q <= tstart_d;
            karg_q   <= karg_d;
            done_q   <= done_d;
            ii_q     <= ii_d;
            last_q   <= last_d;
            pipe_q   <= pipe_d;
        end
    end

    assign gnt    = gnt_q;
    assign tstart = tstart_q;
    assign karg   = karg_q;
    assign done   = done_q;
    assign busy   = tstart_q | any_vld;

endmodule

// File: tb/tb_hir_call_scheduler.sv
// Scoreboard bench for hir_call_scheduler: directed stimulus pushes expected
// grants/dones; negedge monitors pop and compare whenever the DUTs emit one.
module tb_hir_call_scheduler;

    localparam int N   = 4;
    localparam int AW  = 32;
    localparam int LAT = 5;

    typedef struct {
        int          cyc;
        int          id;
        logic [31:0] karg;
    } gexp_t;

    typedef struct {
        int cyc;
        int id;
    } dexp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req0 = '0, req1 = '0;
    logic [N*AW-1:0] arg0 = '0, arg1 = '0;
    logic [N-1:0]    gnt0, gnt1, done0, done1;
    logic            tstart0, tstart1, busy0, busy1;
    logic [AW-1:0]   karg0, karg1;

    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;

    gexp_t exp_g0[$];
    gexp_t exp_g1[$];
    dexp_t exp_d0[$];
    dexp_t exp_d1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    hir_call_scheduler #(.N_CALLERS(N), .ARG_W(AW), .II(2), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .req(req0), .arg(arg0), .gnt(gnt0),
        .tstart(tstart0), .karg(karg0), .done(done0), .busy(busy0)
    );

    hir_call_scheduler #(.N_CALLERS(N), .ARG_W(AW), .II(1), .LATENCY(LAT)) dut1 (
        .clk(clk), .rst(rst), .req(req1), .arg(arg1), .gnt(gnt1),
        .tstart(tstart1), .karg(karg1), .done(done1), .busy(busy1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, cyc, act, expv);
    endtask

    task automatic go_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic exp_call(input int inst, input int gcyc, input int id, input logic [31:0] a);
        gexp_t g;
        dexp_t d;
        g = '{cyc: gcyc, id: id, karg: a};
        d = '{cyc: gcyc + LAT, id: id};
        if (inst == 0) begin
            exp_g0.push_back(g);
            exp_d0.push_back(d);
        end else begin
            exp_g1.push_back(g);
            exp_d1.push_back(d);
        end
    endtask

    task automatic mon_gnt(input int inst, input logic [N-1:0] g, input logic ts, input logic [AW-1:0] ka);
        gexp_t e;
        logic  have;
        have = 1'b0;
        e = '{cyc: 0, id: 0, karg: 0};
        if (inst == 0 && exp_g0.size() > 0) begin
            e = exp_g0.pop_front();
            have = 1'b1;
        end else if (inst == 1 && exp_g1.size() > 0) begin
            e = exp_g1.pop_front();
            have = 1'b1;
        end
        if (!have) begin
            chk($sformatf("dut%0d unexpected grant {gnt,tstart}", inst), {g, ts}, 0);
        end else begin
            chk($sformatf("dut%0d grant cycle", inst), cyc, e.cyc);
            chk($sformatf("dut%0d gnt vector", inst), g, (1 << e.id));
            chk($sformatf("dut%0d tstart", inst), ts, 1);
            chk($sformatf("dut%0d karg", inst), ka, e.karg);
        end
    endtask

    task automatic mon_done(input int inst, input logic [N-1:0] dn);
        dexp_t e;
        logic  have;
        have = 1'b0;
        e = '{cyc: 0, id: 0};
        if (inst == 0 && exp_d0.size() > 0) begin
            e = exp_d0.pop_front();
            have = 1'b1;
        end else if (inst == 1 && exp_d1.size() > 0) begin
            e = exp_d1.pop_front();
            have = 1'b1;
        end
        if (!have) begin
            chk($sformatf("dut%0d unexpected done", inst), dn, 0);
        end else begin
            chk($sformatf("dut%0d done cycle", inst), cyc, e.cyc);
            chk($sformatf("dut%0d done vector", inst), dn, (1 << e.id));
        end
    endtask

    always @(negedge clk) begin
        if (gnt0 != '0 || tstart0) mon_gnt(0, gnt0, tstart0, karg0);
        if (done0 != '0) mon_done(0, done0);
        if (gnt1 != '0 || tstart1) mon_gnt(1, gnt1, tstart1, karg1);
        if (done1 != '0) mon_done(1, done1);
    end

    initial begin
        // Reset held for cycles 0..3
        go_to(3);
        rst = 1'b0;
        go_to(4);
        chk("reset gnt", gnt0, 0);
        chk("reset tstart", tstart0, 0);
        chk("reset karg", karg0, 0);
        chk("reset done", done0, 0);
        chk("reset busy", busy0, 0);

        // Single call from caller 2, with busy window checked cycle by cycle
        go_to(10);
        req0[2] = 1'b1;
        arg0[2*AW +: AW] = 32'h5;
        exp_call(0, 11, 2, 32'h5);
        for (int c = 10; c <= 16; c++) begin
            go_to(c);
            if (c == 11) req0[2] = 1'b0;
            chk($sformatf("busy c%0d", c), busy0, (c >= 11 && c <= 15) ? 1 : 0);
        end

        // Reset pulse so the next burst starts from caller 0
        go_to(18);
        rst = 1'b1;
        go_to(19);
        rst = 1'b0;

        // All four callers requesting, II = 2
        go_to(20);
        for (int i = 0; i < N; i++) begin
            arg0[i*AW +: AW] = 32'h100 + i;
            exp_call(0, 21 + 2*i, i, 32'h100 + i);
        end
        req0 = 4'hF;
        for (int i = 0; i < N; i++) begin
            go_to(21 + 2*i);
            req0[i] = 1'b0;
        end

        // Held req: one grant only; re-raise lands with its own done
        go_to(40);
        req0[1] = 1'b1;
        arg0[1*AW +: AW] = 32'h11;
        exp_call(0, 41, 1, 32'h11);
        go_to(42);
        req0[1] = 1'b0;
        go_to(45);
        req0[1] = 1'b1;
        arg0[1*AW +: AW] = 32'h12;
        exp_call(0, 46, 1, 32'h12);
        go_to(46);
        req0[1] = 1'b0;

        // Withdrawn request while the II counter is nonzero
        go_to(60);
        req0[0] = 1'b1;
        arg0[0*AW +: AW] = 32'hA0;
        exp_call(0, 61, 0, 32'hA0);
        go_to(61);
        req0[0] = 1'b0;
        req0[3] = 1'b1;
        arg0[3*AW +: AW] = 32'hDEAD;
        go_to(62);
        req0[3] = 1'b0;

        // Two calls in flight, then reset: their dones must never appear
        go_to(70);
        req0[3] = 1'b1;
        arg0[3*AW +: AW] = 32'h33;
        gnt_only(71, 3, 32'h33);
        go_to(71);
        req0[3] = 1'b0;
        req0[2] = 1'b1;
        arg0[2*AW +: AW] = 32'h22;
        gnt_only(73, 2, 32'h22);
        go_to(73);
        req0[2] = 1'b0;
        go_to(74);
        rst = 1'b1;
        go_to(75);
        rst = 1'b0;
        for (int c = 75; c <= 80; c++) begin
            go_to(c);
            chk($sformatf("post-rst outputs c%0d", c), {gnt0, tstart0, karg0, done0, busy0}, 0);
        end

        // After reset, caller 0 wins over caller 3
        go_to(82);
        req0[0] = 1'b1;
        req0[3] = 1'b1;
        arg0[0*AW +: AW] = 32'hA5;
        arg0[3*AW +: AW] = 32'h3C;
        exp_call(0, 83, 0, 32'hA5);
        exp_call(0, 85, 3, 32'h3C);
        go_to(83);
        req0[0] = 1'b0;
        go_to(85);
        req0[3] = 1'b0;

        // II = 1 instance: callers 0 and 1 alternate every cycle
        go_to(100);
        arg1[0*AW +: AW] = 32'h30;
        arg1[1*AW +: AW] = 32'h31;
        req1 = 4'b0011;
        for (int c = 101; c <= 108; c++) begin
            exp_call(1, c, (c - 101) % 2, 32'h30 + ((c - 101) % 2));
        end
        go_to(108);
        req1 = '0;

        go_to(120);
        chk("dut0 pending grants", exp_g0.size(), 0);
        chk("dut0 pending dones", exp_d0.size(), 0);
        chk("dut1 pending grants", exp_g1.size(), 0);
        chk("dut1 pending dones", exp_d1.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // A grant whose done is expected to be cancelled by a reset.
    task automatic gnt_only(input int gcyc, input int id, input logic [31:0] a);
        exp_g0.push_back('{cyc: gcyc, id: id, karg: a});
    endtask

endmodule
